regfile_arbiter: RTL
====================

# regfile_arbiter

Two-requester arbiter and access sequencer for the 16×16 general-purpose register file in the instruction-system datapath. Accepts read/write requests from the instruction-fetch side (requester 0) and the execute side (requester 1). Grants them round-robin and drives the register file's address, data_in, wr and cs pins through a fixed four-state access sequence. Returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width (2^ADDR_W entries)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0, req1  in  1  access request from requester 0 / 1
- wr0, wr1  in  1  1 = write, 0 = read
- addr0, addr1  in  ADDR_W  register address
- wdata0, wdata1  in  DATA_W  write data
- ack0, ack1  out  1  one-cycle completion pulse per requester
- rdata  out  DATA_W  read data, valid while ack0/ack1 is high after a read
- busy  out  1  high in any state other than IDLE
- rf_addr  out  ADDR_W  to register file address
- rf_data_in  out  DATA_W  to register file data_in
- rf_wr  out  1  to register file wr
- rf_cs  out  1  to register file cs
- rf_data_out  in  DATA_W  from register file data_out

## Operation
- States are IDLE, SETUP, ACCESS and RESP. All outputs are registered.
- IDLE:
  - If neither request is high, remain in IDLE.
  - If only one request is high, grant it.
  - If both are high, grant the requester selected by the priority pointer `prio`.
  - On grant, latch the requester's id, wr, addr and wdata, then go to SETUP.
- SETUP:
  - rf_addr = latched addr ^ 1, rf_cs = 0, rf_wr = 0.
  - This guarantees the register file sees an address change every access, including repeated accesses to the same address.
  - Always go to ACCESS.
- ACCESS:
  - rf_addr = latched addr, rf_data_in = latched wdata, rf_wr = latched wr, rf_cs = 1.
  - On the exit edge, if the access is a read, capture rf_data_out into rdata.
  - Always go to RESP.
- RESP:
  - rf_cs = 0, rf_wr = 0.
  - ack of the granted requester = 1.
  - Set `prio` to the other requester, then go to IDLE.
- Hold values:
  - rf_addr holds its last value outside SETUP and ACCESS.
  - rf_data_in holds its last value outside ACCESS.
  - rdata holds its value until the next read completes; writes do not change rdata.
- Requester rules:
  - A requester holds req, wr, addr and wdata stable until its ack.
  - It may drop req in the ack cycle or keep it high to issue a new request.
  - A request withdrawn before it is latched in IDLE is simply ignored.
  - Once latched, a transaction always completes unless reset intervenes.
  - A requester that keeps req high after its ack is arbitrated again in the next IDLE. Because `prio` has moved, a waiting peer wins.
- No address or width checks are needed; addr is exactly ADDR_W bits and wraps naturally.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - State = IDLE, prio = 0.
  - ack0 = ack1 = 0, busy = 0.
  - rdata = 0, rf_addr = 0, rf_data_in = 0, rf_wr = 0, rf_cs = 0.
- Latency: with req sampled high at edge 0, SETUP runs after edge 0, ACCESS after edge 1, and RESP (ack high) after edge 2. Idle is reached again after edge 3.
- Throughput: one access per 4 cycles, plus 0 cycles between back-to-back accesses when a request is pending in IDLE. IDLE lasts one cycle minimum.
- Simultaneous req0 and req1 in IDLE resolve strictly by `prio`. Neither requester waits more than one other transaction.
- Reset mid-operation: everything returns to reset values immediately.
  - No ack is issued for the interrupted transaction.
  - A write interrupted in ACCESS may or may not have landed in the register file. The requester must reissue it.

## Structure
- Shared package regfile_arb_pkg contains:
  - state typedef (IDLE, SETUP, ACCESS, RESP; 2-bit encoding);
  - DATA_W and ADDR_W defaults;
  - requester-id constants REQ_FETCH = 0 and REQ_EXEC = 1.
- One natural sub-module: rr_pick2, a combinational two-input round-robin picker.
  - Inputs: req0, req1, prio.
  - Outputs: grant_valid, grant_id.
  - The FSM and all datapath registers stay in regfile_arbiter.

## Test plan
- Read after reset: register file preloaded (mem[0] = 16'h8011); req0 read addr 0 -> ack0 high exactly 3 edges after the request edge, rdata = 16'h8011, ack1 never high.
- Write then read-back: req1 writes 16'h1234 to addr 9, then req1 reads addr 9 -> second ack1 with rdata = 16'h1234; rdata unchanged (previous value) during the write's ack.
- Contention: req0 reads addr 1 and req1 reads addr 2, both held high from the first post-reset edge -> ack0 first (rdata = 16'h8022), then ack1 (rdata = 16'h8123); gap between the two acks is 4 cycles.
- Fairness: both requests permanently high -> acks alternate 0, 1, 0, 1 over 8 transactions; busy low for exactly one cycle between transactions.
- Same-address repeat: req0 reads addr 3 twice back-to-back, with mem[3] changed to 16'hBEEF by a direct register-file write in between -> second rdata = 16'hBEEF (SETUP address toggle verified on rf_addr: 2 then 3).
- Reset in ACCESS: assert rst_n = 0 while a req1 write is in ACCESS -> all outputs immediately at reset values; no ack1; after release, the first request from either requester is served with prio = 0.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file arbiter and its round-robin picker.
package regfile_arb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_EXEC  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-input round-robin picker: a lone request wins outright,
// simultaneous requests are resolved by the priority pointer.
module rr_pick2
    import regfile_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            grant_id = prio;
        end else begin
            grant_id = req1 ? REQ_EXEC : REQ_FETCH;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter that sequences register-file accesses
// through SETUP/ACCESS/RESP and returns read data with a one-cycle ack.
//
// state  | meaning
// IDLE   | waiting for a request; grant and latch the winner
// SETUP  | present addr^1 with cs low so the address always changes
// ACCESS | drive addr/data/wr with cs high; capture read data on exit
// RESP   | pulse ack to the granted requester and rotate priority
module regfile_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              rf_wr,
    output logic              rf_cs,
    input  logic [DATA_W-1:0] rf_data_out
);

    state_t              state, state_nxt;
    logic                prio, prio_nxt;
    logic                id_q, id_nxt;
    logic                wr_q, wr_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic [DATA_W-1:0]   wdata_q, wdata_nxt;
    logic                ack0_nxt, ack1_nxt;
    logic [DATA_W-1:0]   rdata_nxt;
    logic [ADDR_W-1:0]   rf_addr_nxt;
    logic [DATA_W-1:0]   rf_data_in_nxt;
    logic                rf_wr_nxt, rf_cs_nxt;
    logic                grant_valid, grant_id;

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .prio        (prio),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prio       <= REQ_FETCH;
            id_q       <= REQ_FETCH;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            rdata      <= '0;
            rf_addr    <= '0;
            rf_data_in <= '0;
            rf_wr      <= 1'b0;
            rf_cs      <= 1'b0;
        end else begin
            state      <= state_nxt;
            prio       <= prio_nxt;
            id_q       <= id_nxt;
            wr_q       <= wr_nxt;
            addr_q     <= addr_nxt;
            wdata_q    <= wdata_nxt;
            ack0       <= ack0_nxt;
            ack1       <= ack1_nxt;
            busy       <= (state_nxt != IDLE);
            rdata      <= rdata_nxt;
            rf_addr    <= rf_addr_nxt;
            rf_data_in <= rf_data_in_nxt;
            rf_wr      <= rf_wr_nxt;
            rf_cs      <= rf_cs_nxt;
        end
    end

    // Outputs are registered, so each branch computes the values the pins
    // take while sitting in the state being entered.
    always_comb begin
        state_nxt      = state;
        prio_nxt       = prio;
        id_nxt         = id_q;
        wr_nxt         = wr_q;
        addr_nxt       = addr_q;
        wdata_nxt      = wdata_q;
        ack0_nxt       = 1'b0;
        ack1_nxt       = 1'b0;
        rdata_nxt      = rdata;
        rf_addr_nxt    = rf_addr;
        rf_data_in_nxt = rf_data_in;
        rf_wr_nxt      = 1'b0;
        rf_cs_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_nxt   = SETUP;
                    id_nxt      = grant_id;
                    wr_nxt      = grant_id ? wr1 : wr0;
                    addr_nxt    = grant_id ? addr1 : addr0;
                    wdata_nxt   = grant_id ? wdata1 : wdata0;
                    rf_addr_nxt = addr_nxt ^ ADDR_W'(1);
                end
            end
            SETUP: begin
                state_nxt      = ACCESS;
                rf_addr_nxt    = addr_q;
                rf_data_in_nxt = wdata_q;
                rf_wr_nxt      = wr_q;
                rf_cs_nxt      = 1'b1;
            end
            ACCESS: begin
                state_nxt = RESP;
                if (!wr_q) begin
                    rdata_nxt = rf_data_out;
                end
                ack0_nxt = (id_q == REQ_FETCH);
                ack1_nxt = (id_q == REQ_EXEC);
            end
            RESP: begin
                state_nxt = IDLE;
                prio_nxt  = ~id_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
